leaf_user_bridge: RTL and testbench

LEAF_USER_BRIDGE -- requirements
Module: leaf_user_bridge

---
 rtl/leaf_user_bridge_if.sv | 49 ++++
 rtl/leaf_user_bridge.sv | 116 +++++++++++
 tb/tb_leaf_user_bridge.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/leaf_user_bridge_if.sv
// Handshake bundle between the leaf interface, the kernel and leaf_user_bridge.
// The slave modport is the bridge side; master is the system/kernel side.
interface leaf_user_bridge_if #(
  parameter int unsigned PAYLOAD_BITS  = 32,
  parameter int unsigned NUM_IN_PORTS  = 2,
  parameter int unsigned NUM_OUT_PORTS = 2
);
  logic                                    ap_start_in;
  logic                                    ap_start;
  logic                                    busy;
  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]    dout_leaf_interface2user;
  logic [NUM_IN_PORTS-1:0]                 vld_interface2user;
  logic [NUM_IN_PORTS-1:0]                 ack_user2interface;
  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]    kin_data;
  logic [NUM_IN_PORTS-1:0]                 kin_vld;
  logic [NUM_IN_PORTS-1:0]                 kin_ack;
  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   kout_data;
  logic [NUM_OUT_PORTS-1:0]                kout_vld;
  logic [NUM_OUT_PORTS-1:0]                kout_ack;
  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   din_leaf_user2interface;
  logic [NUM_OUT_PORTS-1:0]                vld_user2interface;
  logic [NUM_OUT_PORTS-1:0]                ack_interface2user;

  modport slave (
    input  ap_start_in,
    output ap_start, busy,
    input  dout_leaf_interface2user, vld_interface2user,
    output ack_user2interface,
    output kin_data, kin_vld,
    input  kin_ack,
    input  kout_data, kout_vld,
    output kout_ack,
    output din_leaf_user2interface, vld_user2interface,
    input  ack_interface2user
  );

  modport master (
    output ap_start_in,
    input  ap_start, busy,
    output dout_leaf_interface2user, vld_interface2user,
    input  ack_user2interface,
    input  kin_data, kin_vld,
    output kin_ack,
    output kout_data, kout_vld,
    input  kout_ack,
    input  din_leaf_user2interface, vld_user2interface,
    output ack_interface2user
  );
endinterface

// File: rtl/leaf_user_bridge.sv
// Per-channel FIFOs between the leaf interface and an ap_vld/ap_ack kernel, with an
// IDLE/RUN/DRAIN run controller gating which FIFOs may accept new words.
module leaf_user_bridge #(
  parameter int unsigned PAYLOAD_BITS  = 32,
  parameter int unsigned NUM_IN_PORTS  = 2,
  parameter int unsigned NUM_OUT_PORTS = 2,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input logic               clk,
  input logic               reset,
  leaf_user_bridge_if.slave bus
);
  localparam int unsigned NumCh = NUM_IN_PORTS + NUM_OUT_PORTS;
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CW    = AW + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e state_q, state_d;
  logic   ap_start_q, ap_start_d;

  // Channels 0..NUM_IN_PORTS-1 are leaf->kernel, the rest kernel->leaf.
  logic [NumCh-1:0][PAYLOAD_BITS-1:0] push_data, pop_data;
  logic [NumCh-1:0]                   push_vld, push_en, push_ack;
  logic [NumCh-1:0]                   pop_vld, pop_ack;

  for (genvar i = 0; i < NUM_IN_PORTS; i++) begin : g_in
    assign push_data[i] = bus.dout_leaf_interface2user[i*PAYLOAD_BITS +: PAYLOAD_BITS];
    assign push_vld[i]  = bus.vld_interface2user[i];
    assign push_en[i]   = (state_q == StRun);
    assign pop_ack[i]   = bus.kin_ack[i];
    assign bus.ack_user2interface[i]                    = push_ack[i];
    assign bus.kin_data[i*PAYLOAD_BITS +: PAYLOAD_BITS] = pop_data[i];
    assign bus.kin_vld[i]                               = pop_vld[i];
  end

  for (genvar j = 0; j < NUM_OUT_PORTS; j++) begin : g_out
    assign push_data[NUM_IN_PORTS+j] = bus.kout_data[j*PAYLOAD_BITS +: PAYLOAD_BITS];
    assign push_vld[NUM_IN_PORTS+j]  = bus.kout_vld[j];
    // Kernel results must still be collected while draining.
    assign push_en[NUM_IN_PORTS+j]   = (state_q == StRun) || (state_q == StDrain);
    assign pop_ack[NUM_IN_PORTS+j]   = bus.ack_interface2user[j];
    assign bus.kout_ack[j] = push_ack[NUM_IN_PORTS+j];
    assign bus.din_leaf_user2interface[j*PAYLOAD_BITS +: PAYLOAD_BITS] =
        pop_data[NUM_IN_PORTS+j];
    assign bus.vld_user2interface[j] = pop_vld[NUM_IN_PORTS+j];
  end

  for (genvar c = 0; c < NumCh; c++) begin : g_fifo
    logic [PAYLOAD_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]           wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    full, do_push, do_pop;

    assign full         = (cnt_q == CW'(FIFO_DEPTH));
    assign push_ack[c]  = ~full & push_en[c];
    assign pop_vld[c]   = (cnt_q != '0);
    assign pop_data[c]  = mem_q[rptr_q];
    assign do_push      = push_vld[c] & push_ack[c];
    assign do_pop       = pop_vld[c] & pop_ack[c];

    always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (do_push) wptr_d = wptr_q + AW'(1);
      if (do_pop)  rptr_d = rptr_q + AW'(1);
      if (do_push && !do_pop)      cnt_d = cnt_q + CW'(1);
      else if (!do_push && do_pop) cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        wptr_q <= '0;
        rptr_q <= '0;
        cnt_q  <= '0;
      end else begin
        wptr_q <= wptr_d;
        rptr_q <= rptr_d;
        cnt_q  <= cnt_d;
      end
    end

    // Storage is not reset; stale entries are unreachable once the count is cleared.
    always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q] <= push_data[c];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.ap_start_in) state_d = StRun;
      StRun:   if (!bus.ap_start_in) state_d = StDrain;
      StDrain: begin
        if (bus.ap_start_in)  state_d = StRun;
        else if (~|pop_vld)   state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    ap_start_d = (state_d == StRun);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      ap_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ap_start_q <= ap_start_d;
    end
  end

  assign bus.ap_start = ap_start_q;
  assign bus.busy     = (state_q == StRun) || (state_q == StDrain);
endmodule

// File: tb/tb_leaf_user_bridge.sv
// Random and directed stimulus for leaf_user_bridge, checked against a queue-based
// model of the channel FIFOs and the run controller.
module tb_leaf_user_bridge;
  localparam int unsigned W  = 32;
  localparam int unsigned NI = 2;
  localparam int unsigned NO = 2;
  localparam int unsigned D  = 4;
  localparam int MIdle  = 0;
  localparam int MRun   = 1;
  localparam int MDrain = 2;

  logic clk = 1'b0;
  logic reset;

  leaf_user_bridge_if #(.PAYLOAD_BITS(W), .NUM_IN_PORTS(NI), .NUM_OUT_PORTS(NO)) bus_if ();

  leaf_user_bridge #(
    .PAYLOAD_BITS (W),
    .NUM_IN_PORTS (NI),
    .NUM_OUT_PORTS(NO),
    .FIFO_DEPTH   (D)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int mode    = MIdle;
  logic [W-1:0] q_in  [NI][$];
  logic [W-1:0] q_out [NO][$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic quiet_inputs();
    bus_if.ap_start_in              = 1'b0;
    bus_if.dout_leaf_interface2user = '0;
    bus_if.vld_interface2user       = '0;
    bus_if.kin_ack                  = '0;
    bus_if.kout_data                = '0;
    bus_if.kout_vld                 = '0;
    bus_if.ack_interface2user       = '0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NI; i++) q_in[i].delete();
    for (int j = 0; j < NO; j++) q_out[j].delete();
    mode = MIdle;
  endtask

  // Called just after a falling edge with inputs already applied; compares, advances
  // the model by one rising edge and returns after the next falling edge.
  task automatic cycle();
    logic [NI-1:0] e_iack, e_kvld;
    logic [NO-1:0] e_oack, e_ovld;
    bit all_empty;
    #1;
    all_empty = 1'b1;
    for (int i = 0; i < NI; i++) begin
      e_iack[i] = (mode == MRun) && (q_in[i].size() < D);
      e_kvld[i] = (q_in[i].size() > 0);
      if (e_kvld[i]) begin
        check($sformatf("kin_data%0d", i), bus_if.kin_data[i*W +: W], q_in[i][0]);
        all_empty = 1'b0;
      end
    end
    for (int j = 0; j < NO; j++) begin
      e_oack[j] = (mode != MIdle) && (q_out[j].size() < D);
      e_ovld[j] = (q_out[j].size() > 0);
      if (e_ovld[j]) begin
        check($sformatf("din%0d", j), bus_if.din_leaf_user2interface[j*W +: W], q_out[j][0]);
        all_empty = 1'b0;
      end
    end
    check("ack_user2interface", bus_if.ack_user2interface, e_iack);
    check("kin_vld", bus_if.kin_vld, e_kvld);
    check("kout_ack", bus_if.kout_ack, e_oack);
    check("vld_user2interface", bus_if.vld_user2interface, e_ovld);
    check("busy", bus_if.busy, mode != MIdle);
    check("ap_start", bus_if.ap_start, mode == MRun);
    for (int i = 0; i < NI; i++) begin
      if (e_kvld[i] && bus_if.kin_ack[i]) void'(q_in[i].pop_front());
      if (e_iack[i] && bus_if.vld_interface2user[i])
        q_in[i].push_back(bus_if.dout_leaf_interface2user[i*W +: W]);
    end
    for (int j = 0; j < NO; j++) begin
      if (e_ovld[j] && bus_if.ack_interface2user[j]) void'(q_out[j].pop_front());
      if (e_oack[j] && bus_if.kout_vld[j]) q_out[j].push_back(bus_if.kout_data[j*W +: W]);
    end
    case (mode)
      MIdle:   if (bus_if.ap_start_in) mode = MRun;
      MRun:    if (!bus_if.ap_start_in) mode = MDrain;
      default: begin
        if (bus_if.ap_start_in) mode = MRun;
        else if (all_empty)     mode = MIdle;
      end
    endcase
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    quiet_inputs();
    model_clear();
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_busy", bus_if.busy, 1'b0);
    check("rst_ap_start", bus_if.ap_start, 1'b0);
    check("rst_kin_vld", bus_if.kin_vld, '0);
    check("rst_vld_u2i", bus_if.vld_user2interface, '0);
    @(negedge clk);
    reset = 1'b0;

    // Idle gating: offered words are not accepted.
    bus_if.vld_interface2user = '1;
    bus_if.dout_leaf_interface2user = {$urandom(), $urandom()};
    #1;
    check("idle_gate", bus_if.ack_user2interface, '0);
    cycle();
    bus_if.vld_interface2user = '0;
    bus_if.ap_start_in = 1'b1;
    cycle();

    // Pass-through on in-ch0.
    bus_if.kin_ack = '1;
    bus_if.vld_interface2user = 2'b01;
    bus_if.dout_leaf_interface2user = {32'h0, 32'hA5A5_A5A5};
    cycle();
    bus_if.vld_interface2user = '0;
    #1;
    check("pass_vld", bus_if.kin_vld[0], 1'b1);
    check("pass_data", bus_if.kin_data[0 +: W], 32'hA5A5_A5A5);
    cycle();

    // Full: five offers into in-ch1 with the kernel stalled.
    bus_if.kin_ack = '0;
    bus_if.vld_interface2user = 2'b10;
    for (int k = 0; k < 5; k++) begin
      bus_if.dout_leaf_interface2user = {32'h1000_0000 + k, 32'h0};
      #1;
      check("full_ack", bus_if.ack_user2interface[1], k < 4);
      cycle();
    end
    bus_if.vld_interface2user = '0;
    bus_if.kin_ack = 2'b10;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("full_order", bus_if.kin_data[W +: W], 32'h1000_0000 + k);
      cycle();
    end
    #1;
    check("full_empty", bus_if.kin_vld[1], 1'b0);

    // Simultaneous push and pop with two words held.
    bus_if.kin_ack = '0;
    bus_if.vld_interface2user = 2'b01;
    for (int k = 1; k <= 2; k++) begin
      bus_if.dout_leaf_interface2user = {32'h0, 32'h2000_0000 + k};
      cycle();
    end
    bus_if.dout_leaf_interface2user = {32'h0, 32'h2000_0003};
    bus_if.kin_ack = 2'b01;
    cycle();
    bus_if.vld_interface2user = '0;
    bus_if.kin_ack = '0;
    #1;
    check("simul_head", bus_if.kin_data[0 +: W], 32'h2000_0002);
    cycle();
    bus_if.kin_ack = 2'b01;
    cycle();
    #1;
    check("simul_next", bus_if.kin_data[0 +: W], 32'h2000_0003);
    cycle();
    #1;
    check("simul_cnt2", bus_if.kin_vld[0], 1'b0);

    // Drain with three words in out-ch0.
    bus_if.kin_ack = '1;
    bus_if.kout_vld = 2'b01;
    for (int k = 0; k < 3; k++) begin
      bus_if.kout_data = {32'h0, 32'h3000_0000 + k};
      cycle();
    end
    bus_if.kout_vld = '0;
    bus_if.ap_start_in = 1'b0;
    cycle();
    #1;
    check("drain_ap_start", bus_if.ap_start, 1'b0);
    check("drain_busy", bus_if.busy, 1'b1);
    bus_if.ack_interface2user = 2'b01;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("drain_data", bus_if.din_leaf_user2interface[0 +: W], 32'h3000_0000 + k);
      check("drain_busy_hold", bus_if.busy, 1'b1);
      cycle();
    end
    cycle();
    #1;
    check("drain_idle", bus_if.busy, 1'b0);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 15) == 0) bus_if.ap_start_in = ~bus_if.ap_start_in;
      bus_if.vld_interface2user       = NI'($urandom());
      bus_if.dout_leaf_interface2user = {$urandom(), $urandom()};
      bus_if.kin_ack                  = NI'($urandom());
      bus_if.kout_vld                 = NO'($urandom());
      bus_if.kout_data                = {$urandom(), $urandom()};
      bus_if.ack_interface2user       = NO'($urandom());
      cycle();
    end
    quiet_inputs();
    bus_if.kin_ack = '1;
    bus_if.ack_interface2user = '1;
    for (int n = 0; n < 12; n++) cycle();
    #1;
    check("rand_settle_idle", bus_if.busy, 1'b0);

    // Reset mid-stream with FIFOs half full.
    quiet_inputs();
    bus_if.ap_start_in = 1'b1;
    cycle();
    bus_if.vld_interface2user = '1;
    bus_if.kout_vld = '1;
    for (int n = 0; n < 2; n++) begin
      bus_if.dout_leaf_interface2user = {$urandom(), $urandom()};
      bus_if.kout_data = {$urandom(), $urandom()};
      cycle();
    end
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_kin_vld", bus_if.kin_vld, '0);
    check("mid_rst_vld_u2i", bus_if.vld_user2interface, '0);
    check("mid_rst_ack_u2i", bus_if.ack_user2interface, '0);
    check("mid_rst_kout_ack", bus_if.kout_ack, '0);
    check("mid_rst_busy", bus_if.busy, 1'b0);
    check("mid_rst_ap_start", bus_if.ap_start, 1'b0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    quiet_inputs();
    model_clear();
    cycle();
    bus_if.ap_start_in = 1'b1;
    cycle();
    bus_if.vld_interface2user = 2'b01;
    bus_if.dout_leaf_interface2user = {32'h0, 32'hCAFE_0001};
    cycle();
    bus_if.vld_interface2user = '0;
    bus_if.kin_ack = '1;
    #1;
    check("post_rst_data", bus_if.kin_data[0 +: W], 32'hCAFE_0001);
    cycle();
    cycle();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
